// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Transmit-side scheduler for the UART byte transmitter. Bytes from the
//   bus-side producer are queued in a DEPTH-entry FIFO and handed to the
//   serialiser one frame at a time via a start/byte/busy handshake. The
//   clocks-per-bit divisor is owned here and only updated between frames.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_wr_valid/_data    producer byte offer; o_wr_ready accepts it
//   i_flush             drop every queued (not yet launched) byte
//   i_div_wr, i_div     request a new divisor; o_div_pending while held
//   o_clktobaudrate     divisor currently driven to the transmitter
//   o_start, o_tx_byte  one-cycle launch pulse and the byte being sent
//   i_tx_busy           transmitter busy (rises the cycle after o_start)
//   o_count, o_empty    FIFO occupancy
//   o_idle              queue drained, scheduler idle, transmitter idle
module uart_tx_sched #(
  parameter int          DEPTH       = 16,
  parameter logic [11:0] DEFAULT_DIV = 12'd868
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_valid,
  input  logic [7:0]               i_wr_data,
  output logic                     o_wr_ready,
  input  logic                     i_flush,
  input  logic                     i_div_wr,
  input  logic [11:0]              i_div,
  output logic                     o_div_pending,
  output logic [11:0]              o_clktobaudrate,
  output logic                     o_start,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_busy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [11:0]   div_shadow;
  logic [11:0]   div_active;
  logic          div_pending;

  logic          push;
  logic          pop;
  logic          apply_div;
  logic          is_idle;
  logic          empty;

  assign is_idle   = (state == IDLE);
  assign empty     = (count == '0);

  // No write-through: readiness looks only at the current count, so a full
  // FIFO refuses a write even in a cycle where the head is popped.
  assign o_wr_ready = (count < FULL_COUNT) && !i_flush;
  assign push       = i_wr_valid && o_wr_ready;

  // Divisor changes only while nothing is in flight; it takes priority over
  // launching so the next frame already uses the new rate.
  assign apply_div  = is_idle && div_pending && !i_tx_busy;

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Byte presented to the transmitter; held until the next launch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx_byte <= '0;
    end else if (pop) begin
      o_tx_byte <= mem[rd_ptr];
    end
  end

  // Divisor shadow and active value. A request arriving in the applying
  // cycle is kept pending with its new value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_shadow  <= DEFAULT_DIV;
      div_active  <= DEFAULT_DIV;
      div_pending <= 1'b0;
    end else begin
      if (apply_div) begin
        div_active  <= div_shadow;
        div_pending <= 1'b0;
      end
      if (i_div_wr) begin
        div_shadow  <= i_div;
        div_pending <= 1'b1;
      end
    end
  end

  // Launch FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Launch FSM next-state and outputs
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    o_start    = 1'b0;
    case (state)
      IDLE: begin
        if (div_pending && !i_tx_busy) begin
          state_next = IDLE;
        end else if (!empty && !i_tx_busy && !i_flush) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        o_start    = 1'b1;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_count         = count;
  assign o_empty         = empty;
  assign o_idle          = empty && is_idle && !i_tx_busy;
  assign o_div_pending   = div_pending;
  assign o_clktobaudrate = div_active;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched. Stimulus pushes each byte it expects to
//   be accepted into a scoreboard queue; a monitor pops and compares on every
//   o_start. A simple transmitter model raises busy the cycle after o_start
//   for frame_len cycles; force_busy holds the line busy on demand.
module tb_uart_tx_sched;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          flush;
  logic          div_wr;
  logic [11:0]   div;
  logic          div_pending;
  logic [11:0]   clktobaudrate;
  logic          start;
  logic [7:0]    tx_byte;
  logic          tx_busy;
  logic [CW-1:0] count;
  logic          empty;
  logic          idle;

  logic          frame_busy;
  logic          force_busy;
  assign tx_busy = frame_busy | force_busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int push_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int last_wr_cyc = 0;
  int frame_len = 6;
  int base = 0;
  int mon_exp_count = 0;
  bit cur_acc = 1'b0;
  logic [7:0]  exp_q[$];
  logic [7:0]  cur_byte = 8'h00;
  logic [7:0]  mon_exp = 8'h00;
  logic        prev_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic        prev_rst = 1'b1;
  logic [11:0] prev_div = 12'd868;

  uart_tx_sched #(
    .DEPTH       (DEPTH),
    .DEFAULT_DIV (12'd868)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wr_valid      (wr_valid),
    .i_wr_data       (wr_data),
    .o_wr_ready      (wr_ready),
    .i_flush         (flush),
    .i_div_wr        (div_wr),
    .i_div           (div),
    .o_div_pending   (div_pending),
    .o_clktobaudrate (clktobaudrate),
    .o_start         (start),
    .o_tx_byte       (tx_byte),
    .i_tx_busy       (tx_busy),
    .o_count         (count),
    .o_empty         (empty),
    .o_idle          (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    wr_valid = 1'b1;
    wr_data  = d;
    cur_acc  = acc;
    if (acc) begin
      exp_q.push_back(d);
      push_cnt++;
    end
    @(negedge clk);
    check("wr_ready", wr_ready, acc);
    last_wr_cyc = cyc;
    tick();
    wr_valid = 1'b0;
    cur_acc  = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int bound);
    for (int i = 0; i < bound && start_cnt < target; i++) tick();
    check("start_count", start_cnt, target);
  endtask

  task automatic wait_drained(input int bound);
    for (int i = 0; i < bound && !(idle && exp_q.size() == 0 && !frame_busy); i++) tick();
    check("drained", (idle && exp_q.size() == 0 && !frame_busy), 1);
  endtask

  task automatic wait_frame_busy(input int bound);
    for (int i = 0; i < bound && !frame_busy; i++) tick();
    check("frame_busy_seen", frame_busy, 1);
  endtask

  // Transmitter model: samples o_start, busy from the next cycle on
  initial begin
    frame_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (start) begin
        @(posedge clk);
        #1 frame_busy = 1'b1;
        repeat (frame_len) @(posedge clk);
        #1 frame_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        check("start_has_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check("start_byte", tx_byte, mon_exp);
        end
        check("start_one_cycle", prev_start, 0);
        check("start_while_busy", tx_busy, 0);
        cur_byte = tx_byte;
      end
      if (frame_busy) check("byte_stable", tx_byte, cur_byte);
      mon_exp_count = push_cnt - ((wr_valid && cur_acc) ? 1 : 0) - start_cnt;
      if (!rst && !flush) begin
        check("count", count, mon_exp_count);
        check("empty", empty, (mon_exp_count == 0));
        if (idle) check("idle_drained", (mon_exp_count == 0 && !tx_busy), 1);
      end
      if (clktobaudrate != prev_div && !rst && !prev_rst)
        check("div_change_when_free", prev_busy, 0);
      prev_start = start;
      prev_busy  = tx_busy;
      prev_div   = clktobaudrate;
      prev_rst   = rst;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    flush      = 1'b0;
    div_wr     = 1'b0;
    div        = 12'h000;
    force_busy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    push_cnt = start_cnt;

    // Reset state, single-byte latency
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_start", start, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_div", clktobaudrate, 868);
    check("rst_div_pending", div_pending, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_idle", idle, 1);
    wr(8'hA5, 1'b1);
    wait_starts(1, 20);
    check("start_latency", start_cyc - last_wr_cyc, 2);
    check("byte_a5_held", tx_byte, 8'hA5);
    wait_drained(40);

    // Fill to DEPTH while stalled; full refuses even as a pop occurs
    base = start_cnt;
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) wr(8'(8'h30 + i), 1'b1);
    @(negedge clk);
    check("count_full", count, 16);
    check("ready_full", wr_ready, 0);
    tick();
    force_busy = 1'b0;
    wr(8'hEE, 1'b0);
    wr(8'hEF, 1'b1);
    wait_starts(base + 17, 400);
    wait_drained(50);

    // Divisor request mid-frame, overwritten before it is applied
    base = start_cnt;
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    wait_frame_busy(20);
    div_wr = 1'b1;
    div    = 12'h0FF;
    tick();
    div_wr = 1'b0;
    tick();
    div_wr = 1'b1;
    div    = 12'h1B2;
    tick();
    div_wr = 1'b0;
    @(negedge clk);
    check("div_pending_mid", div_pending, 1);
    check("div_held_mid", clktobaudrate, 868);
    wait_starts(base + 2, 40);
    check("div_applied", clktobaudrate, 12'h1B2);
    check("div_pending_clr", div_pending, 0);
    wait_drained(40);

    // Flush during frame 1 of 5 queued bytes
    base = start_cnt;
    for (int i = 0; i < 5; i++) wr(8'(8'h41 + i), 1'b1);
    @(negedge clk);
    check("count_before_flush", count, 4);
    tick();
    wait_frame_busy(10);
    flush = 1'b1;
    exp_q.delete();
    wr(8'h99, 1'b0);
    flush = 1'b0;
    push_cnt = start_cnt;
    @(negedge clk);
    check("count_after_flush", count, 0);
    check("empty_after_flush", empty, 1);
    tick();
    wait_drained(30);
    repeat (10) tick();
    check("no_start_after_flush", start_cnt, base + 1);

    // Reset while the transmitter is busy, then queue 0x3C
    force_busy = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    push_cnt = start_cnt;
    exp_q.delete();
    check("rst2_count", count, 0);
    check("rst2_div", clktobaudrate, 868);
    check("rst2_div_pending", div_pending, 0);
    check("rst2_tx_byte", tx_byte, 0);
    base = start_cnt;
    wr(8'h3C, 1'b1);
    repeat (10) tick();
    check("no_start_while_busy", start_cnt, base);
    force_busy = 1'b0;
    wait_starts(base + 1, 10);
    wait_drained(30);
    repeat (5) tick();
    check("single_start_after_busy", start_cnt, base + 1);

    // Concurrent push/pop starting from count=3
    frame_len = 2;
    force_busy = 1'b1;
    tick();
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    @(negedge clk);
    check("count_three", count, 3);
    tick();
    force_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1 && (push_cnt - start_cnt) < DEPTH - 2)
        wr(8'($urandom_range(0, 255)), 1'b1);
      else
        tick();
    end
    wait_drained(400);
    check("all_launched", start_cnt, push_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
